// File: rtl/vcpu_run_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : vcpu_run_controller_if
// Brief    : Host, CPU and data-memory signal bundle of the run controller.
// Revision : 1.0
// ============================================================================
interface vcpu_run_controller_if #(
    parameter int I  = 32,
    parameter int N  = 8,
    parameter int R  = 6,
    parameter int CW = 32
);
    // Host run control and memory access
    logic             go;
    logic             abort;
    logic             host_req;
    logic             host_we;
    logic [I-1:0]     host_addr;
    logic [R*N-1:0]   host_wdata;
    logic             host_gnt;
    logic [R*N-1:0]   host_rdata;
    logic             host_rvalid;
    // CPU core side
    logic             cpu_reset;
    logic             cpu_start;
    logic             cpu_end;
    logic             cpu_memwrite;
    logic [I-1:0]     cpu_addr;
    logic [R*N-1:0]   cpu_wdata;
    logic [R*N-1:0]   cpu_rdata;
    // Shared data memory port
    logic             mem_we;
    logic [I-1:0]     mem_addr;
    logic [R*N-1:0]   mem_wdata;
    logic [R*N-1:0]   mem_rdata;
    // Run status
    logic             busy;
    logic             done;
    logic [1:0]       status;
    logic [CW-1:0]    cycles;

    modport slave (
        input  go, abort, host_req, host_we, host_addr, host_wdata,
        input  cpu_end, cpu_memwrite, cpu_addr, cpu_wdata, mem_rdata,
        output host_gnt, host_rdata, host_rvalid, cpu_reset, cpu_start, cpu_rdata,
        output mem_we, mem_addr, mem_wdata, busy, done, status, cycles
    );

    modport master (
        output go, abort, host_req, host_we, host_addr, host_wdata,
        output cpu_end, cpu_memwrite, cpu_addr, cpu_wdata, mem_rdata,
        input  host_gnt, host_rdata, host_rvalid, cpu_reset, cpu_start, cpu_rdata,
        input  mem_we, mem_addr, mem_wdata, busy, done, status, cycles
    );
endinterface
`default_nettype wire

// File: rtl/vcpu_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : vcpu_run_controller
// Brief    : Run-control sequencer and host/CPU data-memory arbiter.
// Revision : 1.0
// ============================================================================
module vcpu_run_controller #(
    parameter int I      = 32,
    parameter int N      = 8,
    parameter int R      = 6,
    parameter int CW     = 32,
    parameter int MAXCYC = 1000000
) (
    input  wire logic             clk,
    input  wire logic             reset,
    vcpu_run_controller_if.slave  bus
);
    localparam int            c_dataW     = R * N;
    localparam logic [CW-1:0] c_lastCycle = CW'(MAXCYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [1:0]           r_status;
    logic [CW-1:0]        r_cycles;
    logic [c_dataW-1:0]   r_hostRdata;
    logic                 r_hostRvalid;
    logic                 w_hostOwns;
    logic                 w_hostGnt;
    logic                 w_hostRead;
    logic                 w_startRun;
    logic                 w_lastCycle;
    logic [I-1:0]         w_memAddr;

    always_comb begin
        w_nextState = r_state;
        w_hostOwns  = (r_state == S_IDLE) || (r_state == S_DONE);
        w_hostGnt   = w_hostOwns & bus.host_req;
        w_hostRead  = w_hostGnt & ~bus.host_we;
        // A pending host access takes precedence; go must be held until it clears
        w_startRun  = w_hostOwns & bus.go & ~bus.host_req;
        w_lastCycle = (r_cycles == c_lastCycle);
        case (r_state)
            S_IDLE, S_DONE: if (w_startRun) w_nextState = S_CLR;
            S_CLR:          w_nextState = S_START;
            S_START:        w_nextState = S_RUN;
            S_RUN:          if (bus.abort || bus.cpu_end || w_lastCycle) w_nextState = S_DONE;
            default:        w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_status     <= 2'b00;
            r_cycles     <= '0;
            r_hostRvalid <= 1'b0;
            r_hostRdata  <= '0;
        end else begin
            r_state      <= w_nextState;
            r_hostRvalid <= w_hostRead;
            if (w_hostRead) begin
                r_hostRdata <= bus.mem_rdata;
            end
            if (w_startRun) begin
                r_cycles <= '0;
                r_status <= 2'b00;
            end else if (r_state == S_RUN) begin
                // Exit cycle leaves the counter frozen at its current value
                if (bus.abort)        r_status <= 2'b11;
                else if (bus.cpu_end) r_status <= 2'b01;
                else if (w_lastCycle) r_status <= 2'b10;
                else                  r_cycles <= r_cycles + 1'b1;
            end
        end
    end

    assign w_memAddr       = w_hostOwns ? bus.host_addr : bus.cpu_addr;

    assign bus.cpu_reset   = reset | (r_state == S_CLR);
    assign bus.cpu_start   = (r_state == S_START);
    assign bus.cpu_rdata   = bus.mem_rdata;
    assign bus.host_gnt    = w_hostGnt;
    assign bus.host_rdata  = r_hostRdata;
    assign bus.host_rvalid = r_hostRvalid;
    assign bus.mem_we      = w_hostOwns ? (bus.host_req & bus.host_we)
                                        : ((r_state == S_RUN) & bus.cpu_memwrite);
    assign bus.mem_addr    = w_memAddr;
    assign bus.mem_wdata   = w_hostOwns ? bus.host_wdata : bus.cpu_wdata;
    assign bus.busy        = (r_state == S_CLR) || (r_state == S_START) || (r_state == S_RUN);
    assign bus.done        = (r_state == S_DONE);
    assign bus.status      = r_status;
    assign bus.cycles      = r_cycles;
endmodule
`default_nettype wire

// File: tb/tb_vcpu_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_vcpu_run_controller
// Brief    : Directed scoreboard bench for the run controller.
// Revision : 1.0
// ============================================================================
module tb_vcpu_run_controller;
    localparam int I  = 32;
    localparam int N  = 8;
    localparam int R  = 6;
    localparam int CW = 32;
    localparam int DW = R * N;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vcpu_run_controller_if #(.I(I), .N(N), .R(R), .CW(CW)) busA ();
    vcpu_run_controller_if #(.I(I), .N(N), .R(R), .CW(CW)) busB ();

    vcpu_run_controller #(.I(I), .N(N), .R(R), .CW(CW), .MAXCYC(1000000)) dutA (
        .clk   (clk),
        .reset (reset),
        .bus   (busA.slave)
    );

    vcpu_run_controller #(.I(I), .N(N), .R(R), .CW(CW), .MAXCYC(5)) dutB (
        .clk   (clk),
        .reset (reset),
        .bus   (busB.slave)
    );

    // Simple data memory behind instance A, combinational read
    logic [DW-1:0] memA [0:15];
    assign busA.mem_rdata = memA[busA.mem_addr[3:0]];
    always @(posedge clk) if (busA.mem_we) memA[busA.mem_addr[3:0]] <= busA.mem_wdata;
    assign busB.mem_rdata = '0;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] rdQ   [$];
    logic [33:0]   runQA [$];
    logic [33:0]   runQB [$];
    logic          prevDoneA = 1'b0;
    logic          prevDoneB = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations when the DUT presents read data or finishes a run
    always @(negedge clk) begin
        if (busA.host_rvalid === 1'b1) begin
            if (rdQ.size() == 0) begin
                checks++; errors++;
                $display("FAIL host_rvalid_unexpected actual=1 expected=0");
            end else begin
                chk("host_rdata", 64'(busA.host_rdata), 64'(rdQ.pop_front()));
            end
        end
        if (busA.done === 1'b1 && !prevDoneA) begin
            if (runQA.size() == 0) begin
                checks++; errors++;
                $display("FAIL doneA_unexpected status=%0d cycles=%0d", busA.status, busA.cycles);
            end else begin
                chk("runA_status_cycles", 64'({busA.status, busA.cycles}), 64'(runQA.pop_front()));
            end
        end
        if (busB.done === 1'b1 && !prevDoneB) begin
            if (runQB.size() == 0) begin
                checks++; errors++;
                $display("FAIL doneB_unexpected status=%0d cycles=%0d", busB.status, busB.cycles);
            end else begin
                chk("runB_status_cycles", 64'({busB.status, busB.cycles}), 64'(runQB.pop_front()));
            end
        end
        prevDoneA <= (busA.done === 1'b1);
        prevDoneB <= (busB.done === 1'b1);
    end

    initial begin
        {busA.go, busA.abort, busA.host_req, busA.host_we, busA.cpu_end, busA.cpu_memwrite} = '0;
        {busB.go, busB.abort, busB.host_req, busB.host_we, busB.cpu_end, busB.cpu_memwrite} = '0;
        busA.host_addr = '0; busA.host_wdata = '0; busA.cpu_addr = '0; busA.cpu_wdata = '0;
        busB.host_addr = '0; busB.host_wdata = '0; busB.cpu_addr = '0; busB.cpu_wdata = '0;
        reset = 1'b1;
        repeat (3) tick();
        chk("cpu_reset_during_reset", 64'(busA.cpu_reset), 64'd1);
        reset = 1'b0;
        #1;

        // Reset / idle state
        chk("idle_busy",        64'(busA.busy),        64'd0);
        chk("idle_done",        64'(busA.done),        64'd0);
        chk("idle_status",      64'(busA.status),      64'd0);
        chk("idle_cycles",      64'(busA.cycles),      64'd0);
        chk("idle_cpu_reset",   64'(busA.cpu_reset),   64'd0);
        chk("idle_cpu_start",   64'(busA.cpu_start),   64'd0);
        chk("idle_host_rvalid", 64'(busA.host_rvalid), 64'd0);
        chk("idle_host_rdata",  64'(busA.host_rdata),  64'd0);
        busA.host_req = 1'b1; #1;
        chk("idle_gnt_req1", 64'(busA.host_gnt), 64'd1);
        busA.host_req = 1'b0; #1;
        chk("idle_gnt_req0", 64'(busA.host_gnt), 64'd0);

        // Host write 0xAA in every lane at address 4
        busA.host_req = 1'b1; busA.host_we = 1'b1; busA.host_addr = 32'd4;
        busA.host_wdata = {R{8'hAA}};
        #1;
        chk("hwr_mem_we",    64'(busA.mem_we),    64'd1);
        chk("hwr_mem_addr",  64'(busA.mem_addr),  64'd4);
        chk("hwr_mem_wdata", 64'(busA.mem_wdata), 64'h0000_AAAA_AAAA_AAAA);
        tick();
        busA.host_req = 1'b0; busA.host_we = 1'b0; #1;
        chk("hwr_mem_we_off", 64'(busA.mem_we), 64'd0);

        // Host read of address 4
        busA.host_req = 1'b1;
        rdQ.push_back({R{8'hAA}});
        tick();
        busA.host_req = 1'b0;
        tick();

        // go together with host_req: access served, go ignored
        busA.go = 1'b1; busA.host_req = 1'b1;
        rdQ.push_back({R{8'hAA}});
        tick();
        chk("go_with_req_busy", 64'(busA.busy), 64'd0);
        busA.host_req = 1'b0;
        tick();
        busA.go = 1'b0;
        chk("clr_cpu_reset", 64'(busA.cpu_reset), 64'd1);
        chk("clr_cpu_start", 64'(busA.cpu_start), 64'd0);
        chk("clr_busy",      64'(busA.busy),      64'd1);
        tick();
        chk("start_cpu_reset", 64'(busA.cpu_reset), 64'd0);
        chk("start_cpu_start", 64'(busA.cpu_start), 64'd1);
        tick();
        chk("run1_cpu_start", 64'(busA.cpu_start), 64'd0);
        chk("run1_cycles",    64'(busA.cycles),    64'd0);
        busA.host_req = 1'b1; busA.cpu_memwrite = 1'b1; busA.cpu_addr = 32'd8;
        busA.cpu_wdata = {R{8'h5C}};
        #1;
        chk("run_host_gnt",  64'(busA.host_gnt),  64'd0);
        chk("run_mem_we1",   64'(busA.mem_we),    64'd1);
        chk("run_mem_addr",  64'(busA.mem_addr),  64'd8);
        chk("run_mem_wdata", 64'(busA.mem_wdata), 64'h0000_5C5C_5C5C_5C5C);
        busA.cpu_memwrite = 1'b0; #1;
        chk("run_mem_we0", 64'(busA.mem_we), 64'd0);
        busA.host_req = 1'b0;
        repeat (9) tick();
        chk("run10_cycles", 64'(busA.cycles), 64'd9);
        busA.cpu_end = 1'b1;
        runQA.push_back({2'b01, 32'd9});
        tick();
        busA.cpu_end = 1'b0;
        chk("end_done", 64'(busA.done), 64'd1);
        chk("end_busy", 64'(busA.busy), 64'd0);
        tick();
        chk("end_cycles_frozen", 64'(busA.cycles), 64'd9);

        // Timeout on the MAXCYC=5 instance
        busB.go = 1'b1;
        tick();
        busB.go = 1'b0;
        repeat (6) tick();
        chk("tmo_run5_done", 64'(busB.done),   64'd0);
        chk("tmo_run5_cyc",  64'(busB.cycles), 64'd4);
        runQB.push_back({2'b10, 32'd4});
        tick();
        chk("tmo_done", 64'(busB.done), 64'd1);

        // Second run from DONE: stale EndFlag/abort ignored, then abort beats cpu_end
        busA.go = 1'b1;
        tick();
        busA.go = 1'b0;
        chk("rerun_cycles_clr", 64'(busA.cycles), 64'd0);
        chk("rerun_status_clr", 64'(busA.status), 64'd0);
        busA.cpu_end = 1'b1; busA.abort = 1'b1;
        tick();
        tick();
        busA.cpu_end = 1'b0; busA.abort = 1'b0;
        chk("stale_end_busy", 64'(busA.busy),   64'd1);
        chk("stale_end_cyc",  64'(busA.cycles), 64'd0);
        tick();
        tick();
        chk("rerun_run3_cyc", 64'(busA.cycles), 64'd2);
        busA.abort = 1'b1; busA.cpu_end = 1'b1;
        runQA.push_back({2'b11, 32'd2});
        tick();
        busA.cpu_end = 1'b0;
        tick();
        busA.abort = 1'b0;
        chk("abort_in_done_done",   64'(busA.done),   64'd1);
        chk("abort_in_done_status", 64'(busA.status), 64'd3);

        // Reset in RUN cycle 3
        busA.go = 1'b1;
        tick();
        busA.go = 1'b0;
        repeat (4) tick();
        chk("rst_run3_cyc", 64'(busA.cycles), 64'd2);
        reset = 1'b1; #1;
        chk("rst_cpu_reset", 64'(busA.cpu_reset), 64'd1);
        tick();
        reset = 1'b0;
        busA.host_req = 1'b1;
        rdQ.push_back({R{8'hAA}});
        #1;
        chk("rst_busy",      64'(busA.busy),      64'd0);
        chk("rst_done",      64'(busA.done),      64'd0);
        chk("rst_status",    64'(busA.status),    64'd0);
        chk("rst_cycles",    64'(busA.cycles),    64'd0);
        chk("rst_host_gnt",  64'(busA.host_gnt),  64'd1);
        chk("rst_cpu_reset", 64'(busA.cpu_reset), 64'd0);
        tick();
        busA.host_req = 1'b0;
        repeat (3) tick();

        chk("rdQ_drained",   64'(rdQ.size()),   64'd0);
        chk("runQA_drained", 64'(runQA.size()), 64'd0);
        chk("runQB_drained", 64'(runQB.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vcpu_run_controller.md
Name: vcpu_run_controller

Overview:
Run-control sequencer and data-memory arbiter for the vector CPU top.
- The host side (loader/readback) owns the shared vector data memory while the CPU is stopped.
- On a go command, the block resets the CPU, pulses its start input and hands the memory port to the CPU.
- It counts execution cycles, ends the run on EndFlag, timeout or abort, then returns the memory to the host with a status code.

Parameters:
I, 32, address width
N, 8, lane width in bits
R, 6, number of lanes per memory word
CW, 32, cycle-counter width
MAXCYC, 1000000, RUN cycle limit before timeout (must be ≥2 and ≤ 2^CW−1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
go  in  1  host request to start a run
abort  in  1  host request to stop a running program
host_req  in  1  host memory access request
host_we  in  1  host access is a write
host_addr  in  I  host word address
host_wdata  in  R×N  host write data
host_gnt  out  1  host access accepted this cycle
host_rdata  out  R×N  registered host read data
host_rvalid  out  1  host_rdata valid
cpu_reset  out  1  reset to the CPU core
cpu_start  out  1  start pulse to the CPU core
cpu_end  in  1  CPU EndFlag
cpu_memwrite  in  1  CPU MemWriteM
cpu_addr  in  I  CPU data address
cpu_wdata  in  R×N  CPU write data
cpu_rdata  out  R×N  read data to the CPU
mem_we  out  1  memory write enable
mem_addr  out  I  memory address
mem_wdata  out  R×N  memory write data
mem_rdata  in  R×N  memory read data (combinational read)
busy  out  1  state is CLR, START or RUN
done  out  1  state is DONE
status  out  2  00 none, 01 ended, 10 timeout, 11 aborted
cycles  out  CW  RUN cycle count

Behaviour:
- States: IDLE, CLR, START, RUN, DONE. Reset value is IDLE, with status=00, cycles=0, host_rvalid=0, host_rdata=0.
- Reset is synchronous and wins over every other input, including mid-run; it returns the block to IDLE in the next cycle.
- cpu_reset = reset OR (state==CLR). cpu_start = (state==START). Both are combinational from the state.
- Memory owner:
  - IDLE/DONE: the host owns the port. host_gnt=host_req; mem_we=host_req&host_we; mem_addr=host_addr; mem_wdata=host_wdata.
  - CLR/START/RUN: the CPU owns the port. mem_we=cpu_memwrite only in RUN (0 in CLR/START); mem_addr=cpu_addr; mem_wdata=cpu_wdata; host_gnt=0.
- cpu_rdata=mem_rdata at all times.
- Host read: when host_gnt&~host_we, host_rdata<=mem_rdata and host_rvalid<=1 the next cycle. Otherwise host_rvalid<=0 and host_rdata holds.
- IDLE/DONE → CLR: on go while host_req=0. If go and host_req are both high, the host access is served and go is ignored; the host must hold go.
- On entering CLR: cycles<=0 and status<=00.
- CLR → START → RUN unconditionally, one cycle each.
- RUN, each cycle, priority order:
  1. abort → DONE with status 11.
  2. cpu_end → DONE with status 01.
  3. cycles==MAXCYC−1 → DONE with status 10.
  4. Otherwise cycles<=cycles+1.
- cycles does not increment on the exit cycle and stays frozen in DONE until the next CLR.
- abort is ignored outside RUN.
- cpu_end is sampled only in RUN. A stale EndFlag during CLR/START is ignored.

Test Plan:
- Reset then idle → busy=0, done=0, status=00, cycles=0, cpu_reset=0, host_gnt follows host_req.
- Host writes 0xAA in every lane at addr 4, then reads addr 4 → mem_we=1 for exactly one cycle; on the read cycle +1, host_rvalid=1 and host_rdata=0xAA in all lanes.
- go with host_req=0; cpu_end asserted on the 10th RUN cycle:
  - cpu_reset high for 1 cycle, then cpu_start high for 1 cycle.
  - done=1, status=01, cycles=9.
  - host_req during RUN → host_gnt=0, mem_we=cpu_memwrite.
- MAXCYC=5, no cpu_end → DONE after 5 RUN cycles, status=10, cycles=4.
- abort and cpu_end in the same RUN cycle → status=11. A second go from DONE → cycles cleared to 0, new run proceeds.
- reset asserted in RUN at cycle 3 → next cycle IDLE, busy=0, status=00, cycles=0, host_gnt follows host_req.
